// File: rtl/add_cp.sv
// Cyclic-prefix insertion for an OFDM transmitter.
// Each symbol of N IFFT output samples is written into one bank of a ping-pong
// buffer. Once a bank is full it is read back as the last CP_LEN samples
// (the cyclic prefix) followed by the whole symbol, N+CP_LEN samples in all.
// The writer can fill the other bank while one is being read. A read that
// finishes with the other bank already full goes straight into the next
// prefix, so the output has no idle cycle between those symbols.

`ifndef N
`define N 512
`endif
`ifndef CP_LEN
`define CP_LEN 32
`endif

module add_cp #(
  parameter int N      = `N,
  parameter int CP_LEN = `CP_LEN,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] di_re,
  input  logic [DATA_W-1:0] di_im,
  input  logic              di_vld,
  output logic              di_rdy,
  output logic [DATA_W-1:0] do_re,
  output logic [DATA_W-1:0] do_im,
  output logic              do_vld,
  output logic              do_sop,
  output logic              do_eop
);

  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] ADDR_LAST = AW'(N - 1);
  localparam logic [AW-1:0] ADDR_CP   = AW'(N - CP_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CP   = 2'd1,
    BODY = 2'd2
  } state_t;

  // Sample storage: two banks of N words, each word packed as {im, re}.
  logic [2*DATA_W-1:0] mem [2][N];

  // Write side
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic          wr_fire;
  logic          wr_last;

  // Bank occupancy. A bank's flag is set on the cycle its last sample is
  // written and cleared on the cycle its last body sample is read.
  logic [1:0] full;
  logic [1:0] full_set;
  logic [1:0] full_clr;

  // Read side
  state_t        state;
  state_t        state_n;
  logic          rd_bank;
  logic          rd_bank_n;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] rd_addr_n;
  logic          rd_en;
  logic          sop_sel;
  logic          eop_sel;
  logic          next_full;

  // Output stage, one clock behind the read cycle
  logic [2*DATA_W-1:0] rd_q_p1;
  logic                vld_p1;
  logic                sop_p1;
  logic                eop_p1;

  // The writer may only fill a bank that has been drained. Holding ready
  // low while rst_n is low keeps upstream from assuming a transfer during
  // reset.
  assign di_rdy  = rst_n & ~full[wr_bank];
  assign wr_fire = di_vld & di_rdy;
  assign wr_last = (wr_addr == ADDR_LAST);

  // Mark the write bank full on the transfer that stores its last sample.
  always_comb begin
    full_set = '0;
    if (wr_fire && wr_last) begin
      full_set[wr_bank] = 1'b1;
    end
  end

  // Write pointer: step through the bank, then move on to the other one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      wr_addr <= '0;
    end else if (wr_fire) begin
      if (wr_last) begin
        wr_bank <= ~wr_bank;
        wr_addr <= '0;
      end else begin
        wr_addr <= wr_addr + 1'b1;
      end
    end
  end

  // Sample RAM write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_bank][wr_addr] <= {di_im, di_re};
    end
  end

  // Bank flags. A write completion on one bank and a read release on the
  // other take effect together on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
    end else begin
      full <= (full | full_set) & ~full_clr;
    end
  end

  // Read FSM state, address and bank registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rd_bank <= 1'b0;
      rd_addr <= '0;
    end else begin
      state   <= state_n;
      rd_bank <= rd_bank_n;
      rd_addr <= rd_addr_n;
    end
  end

  // The other bank counts as ready at the end of a body if it is already
  // full or is being completed on this very edge. Taking the same-edge
  // completion into account keeps the output gap-free when writer and
  // reader finish together.
  assign next_full = full[~rd_bank] | full_set[~rd_bank];

  // Read FSM next state: prefix from N-CP_LEN up to N-1, then body 0..N-1.
  always_comb begin
    state_n   = state;
    rd_bank_n = rd_bank;
    rd_addr_n = rd_addr;
    rd_en     = 1'b0;
    sop_sel   = 1'b0;
    eop_sel   = 1'b0;
    full_clr  = '0;
    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          state_n   = CP;
          rd_addr_n = ADDR_CP;
        end
      end
      CP: begin
        rd_en   = 1'b1;
        sop_sel = (rd_addr == ADDR_CP);
        if (rd_addr == ADDR_LAST) begin
          state_n   = BODY;
          rd_addr_n = '0;
        end else begin
          rd_addr_n = rd_addr + 1'b1;
        end
      end
      BODY: begin
        rd_en = 1'b1;
        if (rd_addr == ADDR_LAST) begin
          eop_sel           = 1'b1;
          full_clr[rd_bank] = 1'b1;
          rd_bank_n         = ~rd_bank;
          if (next_full) begin
            state_n   = CP;
            rd_addr_n = ADDR_CP;
          end else begin
            state_n   = IDLE;
            rd_addr_n = '0;
          end
        end else begin
          rd_addr_n = rd_addr + 1'b1;
        end
      end
      default: begin
        state_n   = IDLE;
        rd_addr_n = '0;
      end
    endcase
  end

  // ---- stage p1: registered RAM read data ----
  // Synchronous RAM read port; the data register carries no reset.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_q_p1 <= mem[rd_bank][rd_addr];
    end
  end

  // Output control flags travel alongside the read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      sop_p1 <= 1'b0;
      eop_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
      sop_p1 <= sop_sel;
      eop_p1 <= eop_sel;
    end
  end

  // Data is forced to zero whenever no sample is presented. This also covers
  // reset, so the unreset data register never leaks stale samples.
  assign do_re  = vld_p1 ? rd_q_p1[DATA_W-1:0]        : '0;
  assign do_im  = vld_p1 ? rd_q_p1[2*DATA_W-1:DATA_W] : '0;
  assign do_vld = vld_p1;
  assign do_sop = sop_p1;
  assign do_eop = eop_p1;

endmodule

// File: tb/tb_add_cp.sv
// Testbench for add_cp: randomized traffic checked against a symbol-level
// reference model (each symbol's last CP samples followed by the whole symbol).
module tb_add_cp;

  localparam int N  = 512;
  localparam int CP = 32;
  localparam int L  = N + CP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] di_re = '0;
  logic [11:0] di_im = '0;
  logic        di_vld = 1'b0;
  logic        di_rdy;
  logic [11:0] do_re;
  logic [11:0] do_im;
  logic        do_vld;
  logic        do_sop;
  logic        do_eop;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] cyc = '0;

  typedef struct packed {
    logic [11:0] re;
    logic [11:0] im;
    logic        sop;
    logic        eop;
    logic [31:0] cyc;
  } obs_t;

  obs_t        outq[$];
  logic [23:0] accq[$];
  logic [23:0] expq[$];
  logic [31:0] rise_cyc[$];
  int          nz_idle = 0;
  int          stall = 0;
  logic        rdy_prev = 1'b0;

  add_cp #(.N(N), .CP_LEN(CP), .DATA_W(12)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .di_re  (di_re),
    .di_im  (di_im),
    .di_vld (di_vld),
    .di_rdy (di_rdy),
    .do_re  (do_re),
    .do_im  (do_im),
    .do_vld (do_vld),
    .do_sop (do_sop),
    .do_eop (do_eop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe handshakes and outputs mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      outq.delete();
      accq.delete();
      rise_cyc.delete();
    end else begin
      if (di_vld && di_rdy) accq.push_back({di_im, di_re});
      if (di_vld && !di_rdy) stall++;
      if (do_vld) outq.push_back({do_re, do_im, do_sop, do_eop, cyc});
      else if (do_re != 0 || do_im != 0 || do_sop || do_eop) nz_idle++;
      if (di_rdy && !rdy_prev) rise_cyc.push_back(cyc);
    end
    rdy_prev = di_rdy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] gen(input int mode, input int k);
    if (mode == 0) return {12'(-k), 12'(k)};
    return 24'($urandom);
  endfunction

  // Offer one symbol of N samples; pct is the di_vld probability in percent.
  task automatic send_sym(input int mode, input int pct, output logic [31:0] last_cyc);
    int k = 0;
    int budget = 0;
    logic [23:0] cur;
    last_cyc = '0;
    cur = gen(mode, 0);
    while (k < N && budget < 20000) begin
      di_vld = ($urandom_range(99) < pct);
      di_re  = cur[11:0];
      di_im  = cur[23:12];
      if (di_vld && di_rdy) begin
        last_cyc = cyc;
        k++;
        cur = gen(mode, k);
      end
      tick();
      budget++;
    end
    di_vld = 1'b0;
  endtask

  task automatic do_reset();
    di_vld = 1'b0;
    rst_n  = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    tick();
    rise_cyc.delete();
    stall = 0;
  endtask

  task automatic wait_out(input int cnt, input int budget);
    int b = 0;
    while (outq.size() < cnt && b < budget) begin
      tick();
      b++;
    end
    repeat (8) tick();
  endtask

  // Reference model: each accepted symbol becomes its last CP samples followed
  // by all N samples. Tallies data, framing-flag and contiguity differences.
  task automatic analyse(input int nsym, output int bad_data, output int bad_mark,
                         output int gap_in, output int gap_between);
    int ns;
    int pos;
    ns = nsym;
    if (accq.size() / N < ns) ns = accq.size() / N;
    expq.delete();
    for (int s = 0; s < ns; s++) begin
      for (int i = N - CP; i < N; i++) expq.push_back(accq[s*N + i]);
      for (int i = 0; i < N; i++) expq.push_back(accq[s*N + i]);
    end
    bad_data = (expq.size() == nsym * L) ? 0 : 1;
    bad_mark = 0;
    gap_in = 0;
    gap_between = 0;
    for (int j = 0; j < outq.size() && j < expq.size(); j++) begin
      pos = j % L;
      if ({outq[j].im, outq[j].re} !== expq[j]) bad_data++;
      if (outq[j].sop !== (pos == 0) || outq[j].eop !== (pos == L - 1)) bad_mark++;
      if (j > 0 && outq[j].cyc != outq[j-1].cyc + 1) begin
        if (pos == 0) gap_between++;
        else gap_in++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    di_vld = 1'b0;
    repeat (2) tick();
    n_cmp++; if (di_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b want 0", di_rdy); end
    n_cmp++; if (do_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", do_vld); end
    n_cmp++; if ({do_re, do_im} !== 24'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {do_re, do_im}); end
    n_cmp++; if ({do_sop, do_eop} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {do_sop, do_eop}); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (di_rdy !== 1'b1) begin n_fail++; $display("FAIL release_rdy: got %b want 1", di_rdy); end
  endtask

  task automatic test_idle();
    int vcnt = 0;
    int rcnt = 0;
    do_reset();
    repeat (1000) begin
      tick();
      if (do_vld) vcnt++;
      if (!di_rdy) rcnt++;
    end
    n_cmp++; if (vcnt !== 0) begin n_fail++; $display("FAIL idle_vld: got %0d valid cycles want 0", vcnt); end
    n_cmp++; if (rcnt !== 0) begin n_fail++; $display("FAIL idle_rdy: got %0d not-ready cycles want 0", rcnt); end
  endtask

  task automatic test_single();
    logic [31:0] lc;
    int bd, bm, gi, gb;
    int bad = 0;
    int k;
    do_reset();
    send_sym(0, 100, lc);
    wait_out(L, 3000);
    n_cmp++; if (outq.size() !== L) begin n_fail++; $display("FAIL single_count: got %0d want %0d", outq.size(), L); end
    for (int j = 0; j < outq.size() && j < L; j++) begin
      k = (j < CP) ? (N - CP + j) : (j - CP);
      if (outq[j].re !== 12'(k) || outq[j].im !== 12'(-k)) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL single_data: got %0d bad samples want 0", bad); end
    analyse(1, bd, bm, gi, gb);
    n_cmp++; if (bm !== 0) begin n_fail++; $display("FAIL single_marks: got %0d bad sop/eop want 0", bm); end
    n_cmp++; if (gi !== 0) begin n_fail++; $display("FAIL single_gaps: got %0d gaps want 0", gi); end
    n_cmp++; if (outq.size() == 0 || outq[0].cyc - lc !== 32'd3) begin
      n_fail++; $display("FAIL single_latency: got %0d cycles want 3", (outq.size() == 0) ? -1 : int'(outq[0].cyc - lc));
    end
  endtask

  task automatic test_random_vld();
    logic [31:0] lc;
    int bd, bm, gi, gb;
    do_reset();
    send_sym(0, 50, lc);
    send_sym(1, 50, lc);
    wait_out(2 * L, 6000);
    analyse(2, bd, bm, gi, gb);
    n_cmp++; if (outq.size() !== 2 * L) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", outq.size(), 2 * L); end
    n_cmp++; if (bd !== 0) begin n_fail++; $display("FAIL rand_data: got %0d bad samples want 0", bd); end
    n_cmp++; if (bm !== 0) begin n_fail++; $display("FAIL rand_marks: got %0d bad sop/eop want 0", bm); end
    n_cmp++; if (gi !== 0) begin n_fail++; $display("FAIL rand_gaps: got %0d gaps want 0", gi); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] lc;
    int bd, bm, gi, gb;
    int bad_rise = 0;
    bit hit;
    do_reset();
    repeat (4) send_sym(1, 100, lc);
    wait_out(4 * L, 8000);
    analyse(4, bd, bm, gi, gb);
    n_cmp++; if (outq.size() !== 4 * L) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", outq.size(), 4 * L); end
    n_cmp++; if (bd !== 0) begin n_fail++; $display("FAIL b2b_data: got %0d bad samples want 0", bd); end
    n_cmp++; if (bm !== 0) begin n_fail++; $display("FAIL b2b_marks: got %0d bad sop/eop want 0", bm); end
    n_cmp++; if (gi + gb !== 0) begin n_fail++; $display("FAIL b2b_gaps: got %0d gaps want 0", gi + gb); end
    n_cmp++; if (!(stall > 0)) begin n_fail++; $display("FAIL b2b_stall: got %0d stalled cycles want >0", stall); end
    // Ready may only return in the cycle after a release edge, which is the
    // cycle that shows the released symbol's eop.
    foreach (rise_cyc[r]) begin
      hit = 1'b0;
      foreach (outq[j]) if (outq[j].eop && outq[j].cyc == rise_cyc[r]) hit = 1'b1;
      if (!hit) bad_rise++;
    end
    n_cmp++; if (bad_rise !== 0 || rise_cyc.size() == 0) begin
      n_fail++; $display("FAIL b2b_rdy_rise: got %0d misplaced of %0d rises want 0 of >0", bad_rise, rise_cyc.size());
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] lc0, lc1, lc2;
    int bd, bm, gi, gb;
    do_reset();
    send_sym(1, 100, lc0);
    // Time the second symbol so its last write lands on the release edge of
    // the first symbol's read (reads span lc0+2 .. lc0+2+L-1).
    while (cyc < lc0 + 34) tick();
    send_sym(1, 100, lc1);
    n_cmp++; if (lc1 !== lc0 + 545) begin n_fail++; $display("FAIL simul_align: got %0d want %0d", lc1 - lc0, 545); end
    n_cmp++; if (di_rdy !== 1'b1) begin n_fail++; $display("FAIL simul_rdy: got %b want 1", di_rdy); end
    send_sym(1, 100, lc2);
    wait_out(3 * L, 6000);
    analyse(3, bd, bm, gi, gb);
    n_cmp++; if (outq.size() !== 3 * L) begin n_fail++; $display("FAIL simul_count: got %0d want %0d", outq.size(), 3 * L); end
    n_cmp++; if (bd !== 0) begin n_fail++; $display("FAIL simul_data: got %0d bad samples want 0", bd); end
    n_cmp++; if (bm !== 0) begin n_fail++; $display("FAIL simul_marks: got %0d bad sop/eop want 0", bm); end
    n_cmp++; if (gi + gb !== 0) begin n_fail++; $display("FAIL simul_gaps: got %0d gaps want 0", gi + gb); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] lc;
    int bd, bm, gi, gb;
    int b = 0;
    int bad = 0;
    int k;
    do_reset();
    send_sym(1, 100, lc);
    while (outq.size() < 100 && b < 3000) begin tick(); b++; end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (do_vld !== 1'b0) begin n_fail++; $display("FAIL midrst_vld: got %b want 0", do_vld); end
    n_cmp++; if ({do_re, do_im, do_sop, do_eop} !== 26'h0) begin
      n_fail++; $display("FAIL midrst_out: got %h want 0", {do_re, do_im, do_sop, do_eop});
    end
    n_cmp++; if (di_rdy !== 1'b0) begin n_fail++; $display("FAIL midrst_rdy: got %b want 0", di_rdy); end
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (di_rdy !== 1'b1) begin n_fail++; $display("FAIL midrst_release_rdy: got %b want 1", di_rdy); end
    repeat (600) tick();
    n_cmp++; if (outq.size() !== 0) begin n_fail++; $display("FAIL midrst_residual: got %0d samples want 0", outq.size()); end
    send_sym(0, 100, lc);
    wait_out(L, 3000);
    n_cmp++; if (outq.size() !== L) begin n_fail++; $display("FAIL midrst_count: got %0d want %0d", outq.size(), L); end
    for (int j = 0; j < outq.size() && j < L; j++) begin
      k = (j < CP) ? (N - CP + j) : (j - CP);
      if (outq[j].re !== 12'(k) || outq[j].im !== 12'(-k)) bad++;
    end
    analyse(1, bd, bm, gi, gb);
    n_cmp++; if (bad + bm !== 0) begin n_fail++; $display("FAIL midrst_data: got %0d bad samples/flags want 0", bad + bm); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_random_vld();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
    n_cmp++; if (nz_idle !== 0) begin n_fail++; $display("FAIL idle_outputs_zero: got %0d nonzero idle cycles want 0", nz_idle); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/add_cp.md
ADD_CP -- requirements
Module: add_cp

Interface
REQ-001 Parameter N, default `N (512), FFT size in samples per symbol.
REQ-002 Parameter CP_LEN, default `CP_LEN (32), cyclic prefix length; SHALL satisfy 0 < CP_LEN < N.
REQ-003 clk  input  1  working clock.
REQ-004 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 di_re  input  12  signed IFFT output sample, real part.
REQ-006 di_im  input  12  signed IFFT output sample, imaginary part.
REQ-007 di_vld  input  1  input sample valid.
REQ-008 di_rdy  output  1  block can accept a sample; transfer occurs when di_vld && di_rdy.
REQ-009 do_re  output  12  signed CP-inserted output sample, real part.
REQ-010 do_im  output  12  signed CP-inserted output sample, imaginary part.
REQ-011 do_vld  output  1  output sample valid; no downstream backpressure.
REQ-012 do_sop  output  1  high with first CP sample of each output symbol.
REQ-013 do_eop  output  1  high with last body sample of each output symbol.

Function
REQ-014 Storage: two banks (ping-pong), each N x 24 bits {im,re}; one full-flag per bank.
REQ-015 Write side: wr_bank, wr_addr 0..N-1; each transfer stores at wr_addr, wr_addr+1.
REQ-016 Transfer with wr_addr == N-1: set full[wr_bank], toggle wr_bank, wr_addr -> 0.
REQ-017 di_rdy = !full[wr_bank], registered-flag based; di_vld while di_rdy low is ignored, no write.
REQ-018 Read FSM states IDLE, CP, BODY; rd_bank, rd_addr.
REQ-019 IDLE: full[rd_bank] -> CP, rd_addr = N-CP_LEN; else stay.
REQ-020 CP: read rd_addr, +1 each cycle; after reading N-1 -> BODY, rd_addr = 0.
REQ-021 BODY: read rd_addr, +1 each cycle; after reading N-1: clear full[rd_bank], toggle rd_bank; other bank full -> CP directly (no gap), else IDLE.
REQ-022 RAM read latency 1 cycle; do_* registered; each read cycle yields exactly one do_vld cycle one clock later.
REQ-023 Per symbol: exactly N+CP_LEN contiguous do_vld cycles; order = samples N-CP_LEN..N-1, then 0..N-1.
REQ-024 First do_vld of a symbol started from IDLE SHALL occur 3 cycles after the cycle accepting that symbol's last input sample.
REQ-025 do_sop with output of address N-CP_LEN in CP state; do_eop with output of address N-1 in BODY state; both 0 otherwise.
REQ-026 do_re, do_im = 0 whenever do_vld = 0.
REQ-027 Sample values pass unmodified; no width change, no rounding.
REQ-028 Simultaneous write-complete on one bank and read-release on the other: both flag updates take effect same edge.
REQ-029 Bank cleared by read-release: di_rdy rises the cycle after the clear edge, never earlier.
REQ-030 Both banks full: di_rdy = 0 until a read-release; no overwrite of unread data ever.
REQ-031 Continuous input with di_vld=1 SHALL yield gap-free output once both banks have filled.

Reset
REQ-032 rst_n low asynchronously: FSM -> IDLE, wr_bank = rd_bank = 0, wr_addr = rd_addr = 0, both full flags = 0.
REQ-033 During reset: do_vld = do_sop = do_eop = 0, do_re = do_im = 0, di_rdy = 0.
REQ-034 di_rdy = 1 in the first cycle after rst_n deasserts; RAM contents need no reset.
REQ-035 Reset mid-symbol discards partial input and any in-progress output; no residual samples emitted after release.

Verification
REQ-036 Single symbol, samples re=k, im=-k (k=0..511) -> 544 do_vld cycles: re 480..511 then 0..511; do_sop on first, do_eop on last; start 3 cycles after last input.
REQ-037 Four back-to-back symbols, di_vld=1 always -> di_rdy drops while both banks full; output 4x544 samples, no do_vld gaps between symbols 1-4, data order exact.
REQ-038 di_vld toggled randomly (50%) -> output identical to REQ-036 data; no sample lost/duplicated.
REQ-039 Write completes bank 1 same cycle read releases bank 0 -> both flags correct; di_rdy high next cycle; next symbol output contiguous.
REQ-040 rst_n asserted at output sample 100 of symbol 0 -> outputs zero immediately; after release di_rdy=1, fresh symbol processed with correct order.
REQ-041 Idle input after reset (di_vld=0, 1000 cycles) -> do_vld never asserts, di_rdy stays 1.
